// File: rtl/global_ldst_ar_splitter.sv
// Global LD/ST read-burst splitter: cuts INCR AR bursts at 4 KiB page boundaries
// and re-stitches R so the requester sees a single last beat per original burst.
package global_ldst_ar_splitter_pkg;
   localparam int unsigned IdWidth   = 4;
   localparam int unsigned AddrWidth = 64;
   localparam int unsigned DataWidth = 512;
   localparam int unsigned StrbWidth = DataWidth / 8;
   localparam int unsigned UserWidth = 1;

   localparam logic [1:0] BurstFixed = 2'b00;
   localparam logic [1:0] BurstIncr  = 2'b01;
   localparam logic [1:0] BurstWrap  = 2'b10;

   typedef struct packed {
      logic [IdWidth-1:0]   id;
      logic [AddrWidth-1:0] addr;
      logic [7:0]           len;
      logic [2:0]           size;
      logic [1:0]           burst;
      logic                 lock;
      logic [3:0]           cache;
      logic [2:0]           prot;
      logic [3:0]           qos;
      logic [3:0]           region;
      logic [5:0]           atop;
      logic [UserWidth-1:0] user;
   } aw_chan_t;

   typedef struct packed {
      logic [DataWidth-1:0] data;
      logic [StrbWidth-1:0] strb;
      logic                 last;
      logic [UserWidth-1:0] user;
   } w_chan_t;

   typedef struct packed {
      logic [IdWidth-1:0]   id;
      logic [1:0]           resp;
      logic [UserWidth-1:0] user;
   } b_chan_t;

   typedef struct packed {
      logic [IdWidth-1:0]   id;
      logic [AddrWidth-1:0] addr;
      logic [7:0]           len;
      logic [2:0]           size;
      logic [1:0]           burst;
      logic                 lock;
      logic [3:0]           cache;
      logic [2:0]           prot;
      logic [3:0]           qos;
      logic [3:0]           region;
      logic [UserWidth-1:0] user;
   } ar_chan_t;

   typedef struct packed {
      logic [IdWidth-1:0]   id;
      logic [DataWidth-1:0] data;
      logic [1:0]           resp;
      logic                 last;
      logic [UserWidth-1:0] user;
   } r_chan_t;

   typedef struct packed {
      aw_chan_t aw;
      logic     aw_valid;
      w_chan_t  w;
      logic     w_valid;
      logic     b_ready;
      ar_chan_t ar;
      logic     ar_valid;
      logic     r_ready;
   } axi_req_t;

   typedef struct packed {
      logic    aw_ready;
      logic    ar_ready;
      logic    w_ready;
      logic    b_valid;
      b_chan_t b;
      logic    r_valid;
      r_chan_t r;
   } axi_resp_t;
endpackage

module global_ldst_ar_splitter #(
   parameter int unsigned AxiAddrWidth   = 64,
   parameter int unsigned AxiDataWidth   = 512,
   parameter int unsigned MaxOutstanding = 4,
   parameter type ar_chan_t  = global_ldst_ar_splitter_pkg::ar_chan_t,
   parameter type axi_req_t  = global_ldst_ar_splitter_pkg::axi_req_t,
   parameter type axi_resp_t = global_ldst_ar_splitter_pkg::axi_resp_t
) (
   input  logic      clk_i,
   input  logic      rst_ni,
   input  axi_req_t  slv_req_i,
   output axi_resp_t slv_resp_o,
   output axi_req_t  mst_req_o,
   input  axi_resp_t mst_resp_i
);
   localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
   localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
   localparam logic [AxiAddrWidth-13:0] PageInc = 1;

   typedef enum logic {
      Idle,
      Issue
   } state_e;

   state_e                  state_q;
   ar_chan_t                piece_q;
   logic [AxiAddrWidth-1:0] cur_addr_q;
   logic [8:0]              rem_beats_q;
   logic [2:0]              piece_cnt_q;
   logic                    ar_valid_q;

   logic [2:0]              fifo_mem_q [MaxOutstanding];
   logic [PtrW-1:0]         rd_ptr_q, wr_ptr_q;
   logic [CntW-1:0]         fifo_cnt_q;
   logic [2:0]              r_piece_cnt_q;

   logic       fifo_full, fifo_empty;
   logic       slv_ar_ready, slv_ar_hs, mst_ar_hs;
   logic       push, pop, r_last_hs, is_final_piece;
   logic [2:0] head_last;
   logic [8:0] piece_beats;

   // Beats the current piece may carry: INCR stops at the next page edge,
   // FIXED/WRAP are passed as one piece.
   function automatic logic [8:0] calc_piece_beats(input logic [11:0] pg_off,
                                                   input logic [2:0]  size,
                                                   input logic [1:0]  burst,
                                                   input logic [8:0]  rem);
      logic [11:0] aligned;
      logic [12:0] to_pg;
      logic [8:0]  beats;
      aligned = pg_off & ~((12'd1 << size) - 12'd1);
      to_pg   = (13'd4096 - {1'b0, aligned}) >> size;
      beats   = rem;
      if (burst == global_ldst_ar_splitter_pkg::BurstIncr && {4'd0, rem} > to_pg) begin
         beats = to_pg[8:0];
      end
      return beats;
   endfunction

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
      return (ptr == PtrW'(MaxOutstanding - 1)) ? '0 : ptr + PtrW'(1);
   endfunction

   assign fifo_full    = (fifo_cnt_q == CntW'(MaxOutstanding));
   assign fifo_empty   = (fifo_cnt_q == '0);
   assign slv_ar_ready = (state_q == Idle) && !fifo_full;
   assign slv_ar_hs    = slv_req_i.ar_valid && slv_ar_ready;
   assign mst_ar_hs    = ar_valid_q && mst_resp_i.ar_ready;
   assign piece_beats  = calc_piece_beats(cur_addr_q[11:0], piece_q.size, piece_q.burst,
                                          rem_beats_q);
   assign push         = mst_ar_hs && (rem_beats_q == piece_beats);

   assign head_last      = fifo_mem_q[rd_ptr_q] - 3'd1;
   assign is_final_piece = (r_piece_cnt_q == head_last);
   assign r_last_hs      = mst_resp_i.r_valid && slv_req_i.r_ready && mst_resp_i.r.last
                           && !fifo_empty;
   assign pop            = r_last_hs && is_final_piece;

   always_comb begin
      mst_req_o          = slv_req_i;
      mst_req_o.ar       = piece_q;
      mst_req_o.ar.addr  = cur_addr_q;
      // A 256-beat piece wraps [7:0] to 0, so minus one still yields len 255.
      mst_req_o.ar.len   = piece_beats[7:0] - 8'd1;
      mst_req_o.ar_valid = ar_valid_q;
   end

   always_comb begin
      slv_resp_o          = mst_resp_i;
      slv_resp_o.ar_ready = slv_ar_ready;
      slv_resp_o.r.last   = mst_resp_i.r.last && (fifo_empty || is_final_piece);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= Idle;
         ar_valid_q  <= 1'b0;
         piece_q     <= '0;
         cur_addr_q  <= '0;
         rem_beats_q <= '0;
         piece_cnt_q <= '0;
      end else begin
         case (state_q)
            Idle: begin
               if (slv_ar_hs) begin
                  piece_q     <= slv_req_i.ar;
                  cur_addr_q  <= slv_req_i.ar.addr;
                  rem_beats_q <= {1'b0, slv_req_i.ar.len} + 9'd1;
                  piece_cnt_q <= '0;
                  ar_valid_q  <= 1'b1;
                  state_q     <= Issue;
               end
            end
            Issue: begin
               if (mst_ar_hs) begin
                  rem_beats_q <= rem_beats_q - piece_beats;
                  cur_addr_q  <= {cur_addr_q[AxiAddrWidth-1:12] + PageInc, 12'h000};
                  piece_cnt_q <= piece_cnt_q + 3'd1;
                  if (push) begin
                     ar_valid_q <= 1'b0;
                     state_q    <= Idle;
                  end
               end
            end
            default: state_q <= Idle;
         endcase
      end
   end

   // Piece-count tracker, one entry per original burst in flight.
   always_ff @(posedge clk_i) begin
      if (push) begin
         fifo_mem_q[wr_ptr_q] <= piece_cnt_q + 3'd1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_ptr_q      <= '0;
         wr_ptr_q      <= '0;
         fifo_cnt_q    <= '0;
         r_piece_cnt_q <= '0;
      end else begin
         if (push) begin
            wr_ptr_q <= ptr_inc(wr_ptr_q);
         end
         if (pop) begin
            rd_ptr_q      <= ptr_inc(rd_ptr_q);
            r_piece_cnt_q <= '0;
         end else if (r_last_hs) begin
            r_piece_cnt_q <= r_piece_cnt_q + 3'd1;
         end
         if (push && !pop) begin
            fifo_cnt_q <= fifo_cnt_q + CntW'(1);
         end else if (pop && !push) begin
            fifo_cnt_q <= fifo_cnt_q - CntW'(1);
         end
      end
   end
endmodule

// File: tb/tb_global_ldst_ar_splitter.sv
// Directed bench for global_ldst_ar_splitter: page splitting, R last stitching,
// backpressure, outstanding limit and reset mid-split.
module tb_global_ldst_ar_splitter;
   import global_ldst_ar_splitter_pkg::*;

   logic      clk = 1'b0;
   logic      rst_ni;
   axi_req_t  slv_req, mst_req;
   axi_resp_t slv_resp, mst_resp;
   int        n_pass  = 0;
   int        n_fail  = 0;
   int        n_total = 0;
   int        last_cnt, last_idx;

   always #5 clk = ~clk;

   global_ldst_ar_splitter dut (
      .clk_i      (clk),
      .rst_ni     (rst_ni),
      .slv_req_i  (slv_req),
      .slv_resp_o (slv_resp),
      .mst_req_o  (mst_req),
      .mst_resp_i (mst_resp)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_ar(input string tag, input logic [63:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
      slv_req.ar.addr  = addr;
      slv_req.ar.len   = len;
      slv_req.ar.size  = size;
      slv_req.ar.burst = burst;
      slv_req.ar.id    = 4'h5;
      slv_req.ar_valid = 1'b1;
      #1;
      chk({tag, "_slv_ar_ready"}, 64'(slv_resp.ar_ready), 64'd1);
      tick();
      slv_req.ar_valid = 1'b0;
   endtask

   task automatic expect_piece(input string tag, input logic [63:0] addr, input logic [7:0] len);
      chk({tag, "_vld"}, 64'(mst_req.ar_valid), 64'd1);
      chk({tag, "_addr"}, mst_req.ar.addr, addr);
      chk({tag, "_len"}, 64'(mst_req.ar.len), 64'(len));
      chk({tag, "_slv_rdy"}, 64'(slv_resp.ar_ready), 64'd0);
      tick();
   endtask

   task automatic r_beat(input string tag, input logic last_in, input logic exp_last);
      mst_resp.r_valid = 1'b1;
      mst_resp.r.last  = last_in;
      #1;
      chk(tag, 64'(slv_resp.r.last), 64'(exp_last));
      tick();
      mst_resp.r_valid = 1'b0;
      mst_resp.r.last  = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      slv_req  = '0;
      mst_resp = '0;
      rst_ni   = 1'b0;
      slv_req.r_ready     = 1'b1;
      mst_resp.ar_ready   = 1'b1;
      // Reset state and pass-through channels
      slv_req.aw_valid    = 1'b1;
      slv_req.aw.addr     = 64'hDEAD_0000;
      slv_req.w_valid     = 1'b1;
      slv_req.w.data[63:0] = 64'h0123_4567_89AB_CDEF;
      mst_resp.aw_ready   = 1'b1;
      mst_resp.b_valid    = 1'b1;
      mst_resp.b.resp     = 2'b10;
      mst_resp.r.data[63:0] = 64'hCAFE_F00D;
      #2;
      chk("rst_mst_ar_valid", 64'(mst_req.ar_valid), 64'd0);
      chk("rst_slv_ar_ready", 64'(slv_resp.ar_ready), 64'd1);
      chk("pt_aw_addr", mst_req.aw.addr, 64'hDEAD_0000);
      chk("pt_w_data", mst_req.w.data[63:0], 64'h0123_4567_89AB_CDEF);
      chk("pt_aw_ready", 64'(slv_resp.aw_ready), 64'd1);
      chk("pt_b_resp", 64'(slv_resp.b.resp), 64'd2);
      chk("pt_r_data", slv_resp.r.data[63:0], 64'hCAFE_F00D);
      slv_req.aw_valid  = 1'b0;
      slv_req.w_valid   = 1'b0;
      mst_resp.b_valid  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_ni = 1'b1;
      tick();

      // In-page burst
      send_ar("s1", 64'h1000, 8'd7, 3'd6, BurstIncr);
      expect_piece("s1_p1", 64'h1000, 8'd7);
      chk("s1_idle_vld", 64'(mst_req.ar_valid), 64'd0);
      chk("s1_idle_rdy", 64'(slv_resp.ar_ready), 64'd1);
      for (int i = 0; i < 8; i++) r_beat($sformatf("s1_r%0d", i), i == 7, i == 7);

      // Crossing burst
      send_ar("s2", 64'h1F80, 8'd3, 3'd6, BurstIncr);
      expect_piece("s2_p1", 64'h1F80, 8'd1);
      expect_piece("s2_p2", 64'h2000, 8'd1);
      chk("s2_idle_vld", 64'(mst_req.ar_valid), 64'd0);
      r_beat("s2_r0", 1'b0, 1'b0);
      r_beat("s2_r1", 1'b1, 1'b0);
      r_beat("s2_r2", 1'b0, 1'b0);
      r_beat("s2_r3", 1'b1, 1'b1);

      // Max burst, 5 pieces
      send_ar("s3", 64'h0040, 8'd255, 3'd6, BurstIncr);
      expect_piece("s3_p1", 64'h0040, 8'd62);
      expect_piece("s3_p2", 64'h1000, 8'd63);
      expect_piece("s3_p3", 64'h2000, 8'd63);
      expect_piece("s3_p4", 64'h3000, 8'd63);
      expect_piece("s3_p5", 64'h4000, 8'd0);
      chk("s3_idle_vld", 64'(mst_req.ar_valid), 64'd0);
      last_cnt = 0;
      last_idx = -1;
      for (int i = 0; i < 256; i++) begin
         mst_resp.r_valid = 1'b1;
         mst_resp.r.last  = (i == 62 || i == 126 || i == 190 || i == 254 || i == 255);
         #1;
         if (slv_resp.r.last) begin
            last_cnt++;
            last_idx = i;
         end
         tick();
      end
      mst_resp.r_valid = 1'b0;
      mst_resp.r.last  = 1'b0;
      chk("s3_last_count", 64'(last_cnt), 64'd1);
      chk("s3_last_beat", 64'(last_idx), 64'd255);

      // FIXED burst across a page is never split
      send_ar("s4", 64'h1F80, 8'd3, 3'd6, BurstFixed);
      expect_piece("s4_p1", 64'h1F80, 8'd3);
      chk("s4_idle_vld", 64'(mst_req.ar_valid), 64'd0);
      for (int i = 0; i < 4; i++) r_beat($sformatf("s4_r%0d", i), i == 3, i == 3);

      // Backpressure on a split burst
      mst_resp.ar_ready = 1'b0;
      send_ar("s5", 64'h5FC0, 8'd3, 3'd6, BurstIncr);
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("s5_stall%0d_vld", i), 64'(mst_req.ar_valid), 64'd1);
         chk($sformatf("s5_stall%0d_addr", i), mst_req.ar.addr, 64'h5FC0);
         chk($sformatf("s5_stall%0d_len", i), 64'(mst_req.ar.len), 64'd0);
         chk($sformatf("s5_stall%0d_rdy", i), 64'(slv_resp.ar_ready), 64'd0);
         tick();
      end
      mst_resp.ar_ready = 1'b1;
      #1;
      expect_piece("s5_p1", 64'h5FC0, 8'd0);
      expect_piece("s5_p2", 64'h6000, 8'd2);
      chk("s5_idle_vld", 64'(mst_req.ar_valid), 64'd0);
      r_beat("s5_r0", 1'b1, 1'b0);
      r_beat("s5_r1", 1'b0, 1'b0);
      r_beat("s5_r2", 1'b0, 1'b0);
      r_beat("s5_r3", 1'b1, 1'b1);

      // Outstanding limit
      for (int k = 0; k < 4; k++) begin
         send_ar($sformatf("s6_ar%0d", k), 64'(k * 256), 8'd0, 3'd6, BurstIncr);
         expect_piece($sformatf("s6_p%0d", k), 64'(k * 256), 8'd0);
      end
      slv_req.ar.addr  = 64'h0800;
      slv_req.ar.len   = 8'd0;
      slv_req.ar_valid = 1'b1;
      #1;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("s6_full%0d_rdy", i), 64'(slv_resp.ar_ready), 64'd0);
         tick();
      end
      mst_resp.r_valid = 1'b1;
      mst_resp.r.last  = 1'b1;
      #1;
      chk("s6_r0_last", 64'(slv_resp.r.last), 64'd1);
      chk("s6_r0_rdy", 64'(slv_resp.ar_ready), 64'd0);
      tick();
      mst_resp.r_valid = 1'b0;
      mst_resp.r.last  = 1'b0;
      #1;
      chk("s6_after_pop_rdy", 64'(slv_resp.ar_ready), 64'd1);
      chk("s6_after_pop_vld", 64'(mst_req.ar_valid), 64'd0);
      tick();
      slv_req.ar_valid = 1'b0;
      expect_piece("s6_p4", 64'h0800, 8'd0);
      for (int i = 0; i < 4; i++) r_beat($sformatf("s6_drain%0d", i), 1'b1, 1'b1);

      // Empty tracker: last forwarded as received
      r_beat("s7_empty_nolast", 1'b0, 1'b0);
      r_beat("s7_empty_last", 1'b1, 1'b1);

      // Reset during piece 2 of the crossing burst
      send_ar("s8", 64'h1F80, 8'd3, 3'd6, BurstIncr);
      expect_piece("s8_p1", 64'h1F80, 8'd1);
      chk("s8_p2_addr", mst_req.ar.addr, 64'h2000);
      rst_ni = 1'b0;
      #1;
      chk("s8_rst_vld", 64'(mst_req.ar_valid), 64'd0);
      chk("s8_rst_rdy", 64'(slv_resp.ar_ready), 64'd1);
      tick();
      rst_ni = 1'b1;
      tick();
      send_ar("s9", 64'h1000, 8'd7, 3'd6, BurstIncr);
      expect_piece("s9_p1", 64'h1000, 8'd7);
      chk("s9_idle_vld", 64'(mst_req.ar_valid), 64'd0);
      for (int i = 0; i < 8; i++) r_beat($sformatf("s9_r%0d", i), i == 7, i == 7);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/global_ldst_ar_splitter.md
# global_ldst_ar_splitter

Downstream stage of the global load/store unit. It sits between the global LD/ST merge stage and the system AXI crossbar, and closes that stage's open gap of read bursts crossing 4 KiB page boundaries. Each incoming INCR read burst is split into page-legal sub-bursts. The R stream is re-stitched so the requester sees exactly one `r.last`, on the final beat of the original burst. AW/W/B pass through untouched.

## Interface
- `AxiAddrWidth`, default 64: AXI address width.
- `AxiDataWidth`, default 512: system AXI data width; `size` ≤ log2(AxiDataWidth/8).
- `MaxOutstanding`, default 4: max original read bursts in flight (tracker FIFO depth, power of 2).
- `axi_req_t` / `axi_resp_t`, default logic: system AXI request/response structs.
- `clk_i  in  1  clock`
- `rst_ni  in  1  reset, asynchronous, active-low`
- `slv_req_i  in  axi_req_t  request from global LD/ST stage`
- `slv_resp_o  out  axi_resp_t  response to global LD/ST stage`
- `mst_req_o  out  axi_req_t  request to system crossbar`
- `mst_resp_i  in  axi_resp_t  response from system crossbar`

## Operation
- AW, W, B, `aw_ready`, `w_ready`, `b_valid`/`b`, `b_ready`: combinational pass-through.
- The AR FSM has two states: IDLE and ISSUE.
  - IDLE: `slv ar_ready = !fifo_full`. On handshake, latch `ar` into a piece register (`cur_addr`, `rem_beats = len+1`, `size`, other fields) and go to ISSUE.
  - ISSUE: `mst ar_valid = 1`, carrying the latched fields except `addr = cur_addr` and `len = piece_beats-1`.
- `piece_beats`:
  - `beats_to_pg = (4096 - aligned(cur_addr,size)[11:0]) >> size`.
  - `piece_beats = min(rem_beats, beats_to_pg)`.
- On `mst ar` handshake:
  - `rem_beats -= piece_beats` and `cur_addr = {cur_addr[AW-1:12]+1, 12'h000}`.
  - If `rem_beats` becomes 0, return to IDLE.
- Only the first piece keeps the unaligned start address. Later pieces start page-aligned.
- FIXED/WRAP bursts are never split: they are issued as one piece equal to the input.
- Piece count per burst is at most 5 (256 beats × 64 B = 16 KiB, offset start). It is counted in a 3-bit counter during ISSUE and pushed into the tracker FIFO on the last piece's handshake.
- R path is combinational:
  - `slv r_valid = mst r_valid`; `mst r_ready = slv r_ready`.
  - `slv r = mst r`, except `r.last = mst r.last && (r_piece_cnt == fifo_head-1)`.
- On an R handshake with `mst r.last`:
  - If this is the final piece: pop the FIFO and clear `r_piece_cnt`.
  - Otherwise: increment `r_piece_cnt`.
- R responses return in AR issue order; the block does no ID reordering.
- An R beat arriving with the FIFO empty is forwarded unchanged with `last` as received, and no pop occurs.
- Push and pop in the same cycle are both performed; occupancy is unchanged.

## Timing
- Reset values:
  - `mst ar_valid=0`, `slv ar_ready=1`.
  - FSM in IDLE; FIFO empty; `r_piece_cnt=0`; piece registers 0.
  - Pass-through outputs follow their inputs.
- AR latency is 1 cycle: a slave AR handshake at cycle t makes the first piece valid at t+1.
- An n-piece burst occupies ISSUE for at least n cycles; `slv ar_ready=0` throughout ISSUE.
- `mst ar` is held stable while `mst ar_ready=0`.
- R latency is 0 cycles, with no R buffering.
- `fifo_full` blocks new ARs in IDLE only. An ISSUE already in progress always completes its push, because the AR was accepted only when `!fifo_full`.
- Reset mid-split drops all state immediately. The crossbar must be reset together with this block.

## Test plan
- In-page burst: `addr=0x1000, size=6, len=7` → one mst AR with `addr 0x1000, len 7`; 8 R beats; `slv r.last` on beat 8 only.
- Crossing burst: `addr=0x1F80, size=6, len=3`:
  - mst ARs `0x1F80 len 1` then `0x2000 len 1`, on consecutive cycles with `ar_ready=1`.
  - `mst r.last` on beat 2 is suppressed; `slv r.last` is asserted on beat 4.
- Max burst: `addr=0x0040, size=6, len=255`:
  - Pieces: `0x0040 len 62`, `0x1000 len 63`, `0x2000 len 63`, `0x3000 len 63`, `0x4000 len 0`.
  - Exactly one `slv r.last`, on beat 256.
- Backpressure: `mst ar_ready=0` for 5 cycles during ISSUE → `mst ar` stable; `slv ar_ready=0`; the piece is issued in the cycle `ar_ready` rises.
- Outstanding limit with `MaxOutstanding=4`: issue 4 single-beat ARs with no R → the 5th AR stalls (`slv ar_ready=0`). It is accepted in the cycle after the first burst's R `last` handshake.
- Reset mid-ISSUE: assert `rst_ni=0` during piece 2 of the crossing burst → `mst ar_valid=0` immediately; after release, a new in-page burst behaves as in the first scenario.
